// File: rtl/dcache_qspi.sv
`default_nettype none
// ==== dcache_qspi : quad-SPI PSRAM line fill / victim write-back engine for the nibble cache (rev 1.0) ====
module dcache_qspi #(
  parameter int          LINE_LENGTH = 4,
  parameter int          PA          = 22,
  parameter logic [7:0]  RD_CMD      = 8'hEB,
  parameter logic [7:0]  WR_CMD      = 8'h38,
  parameter int          RD_DUMMY    = 6
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 req,
  input  logic                                 push,
  input  logic                                 pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]    tag,
  input  logic [3:0]                           dwrite,
  output logic [3:0]                           dread,
  output logic                                 wstrobe_d,
  output logic                                 rstrobe_d,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 qspi_sck,
  output logic                                 qspi_cs_n,
  output logic                                 qspi_oe,
  output logic [3:0]                           qspi_out,
  input  logic [3:0]                           qspi_in
);

  localparam int          c_nn         = 2 * LINE_LENGTH;
  localparam int          c_offw       = $clog2(LINE_LENGTH);
  localparam int          c_iw         = $clog2(c_nn);
  localparam logic [7:0]  c_nn_last    = 8'(c_nn - 1);
  localparam logic [7:0]  c_fill_last  = 8'(c_nn - 2);
  localparam logic [7:0]  c_dummy_last = 8'(RD_DUMMY - 1);
  localparam logic [c_iw-1:0] c_one    = 1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    GRAB  = 4'd1,
    CMD   = 4'd2,
    ADDR  = 4'd3,
    DUMMY = 4'd4,
    XFER  = 4'd5,
    DESEL = 4'd6,
    FILL  = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t          r_state;
  logic            r_phase;
  logic [7:0]      r_cnt;
  logic            r_push;
  logic [31:0]     r_sr;
  logic [3:0]      r_buf [c_nn];

  logic [23:0]     w_addr;
  logic [31:0]     w_cmd_addr;
  logic [c_iw-1:0] w_idx;
  logic [c_iw-1:0] w_idx_nx;

  assign w_addr     = {{(24-PA){1'b0}}, tag, {c_offw{1'b0}}};
  assign w_cmd_addr = {(push ? WR_CMD : RD_CMD), w_addr};
  assign w_idx      = r_cnt[c_iw-1:0];
  assign w_idx_nx   = w_idx + c_one;

  // Command and address leave r_sr MS nibble first; qspi_out always holds the
  // nibble of the current slot, so the shift register runs one nibble ahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_phase   <= 1'b0;
      r_cnt     <= '0;
      r_push    <= 1'b0;
      r_sr      <= '0;
      for (int i = 0; i < c_nn; i++) r_buf[i] <= 4'h0;
      dread     <= 4'h0;
      wstrobe_d <= 1'b0;
      rstrobe_d <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      qspi_sck  <= 1'b0;
      qspi_cs_n <= 1'b1;
      qspi_oe   <= 1'b0;
      qspi_out  <= 4'h0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req && (push || pull)) begin
            r_push  <= push;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            if (push) begin
              r_sr      <= w_cmd_addr;
              rstrobe_d <= 1'b1;
              r_state   <= GRAB;
            end else begin
              r_sr      <= {w_cmd_addr[27:0], 4'h0};
              qspi_out  <= w_cmd_addr[31:28];
              qspi_cs_n <= 1'b0;
              qspi_oe   <= 1'b1;
              r_state   <= CMD;
            end
          end
        end
        GRAB: begin
          r_buf[w_idx] <= dwrite;
          if (r_cnt == c_nn_last) begin
            rstrobe_d <= 1'b0;
            r_cnt     <= '0;
            r_sr      <= {r_sr[27:0], 4'h0};
            qspi_out  <= r_sr[31:28];
            qspi_cs_n <= 1'b0;
            qspi_oe   <= 1'b1;
            r_state   <= CMD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        CMD, ADDR, DUMMY, XFER: begin
          qspi_sck <= ~r_phase;
          r_phase  <= ~r_phase;
          if (r_phase) begin
            r_cnt <= r_cnt + 8'd1;
            case (r_state)
              CMD: begin
                qspi_out <= r_sr[31:28];
                r_sr     <= {r_sr[27:0], 4'h0};
                if (r_cnt == 8'd1) begin
                  r_cnt   <= '0;
                  r_state <= ADDR;
                end
              end
              ADDR: begin
                if (r_cnt == 8'd5) begin
                  r_cnt <= '0;
                  if (r_push) begin
                    qspi_out <= r_buf[0];
                    r_state  <= XFER;
                  end else begin
                    qspi_oe  <= 1'b0;
                    qspi_out <= 4'h0;
                    r_state  <= DUMMY;
                  end
                end else begin
                  qspi_out <= r_sr[31:28];
                  r_sr     <= {r_sr[27:0], 4'h0};
                end
              end
              DUMMY: begin
                if (r_cnt == c_dummy_last) begin
                  r_cnt   <= '0;
                  r_state <= XFER;
                end
              end
              default: begin
                if (!r_push) r_buf[w_idx] <= qspi_in;
                if (r_cnt == c_nn_last) begin
                  r_cnt     <= '0;
                  qspi_cs_n <= 1'b1;
                  qspi_oe   <= 1'b0;
                  qspi_out  <= 4'h0;
                  r_state   <= DESEL;
                end else if (r_push) begin
                  qspi_out <= r_buf[w_idx_nx];
                end
              end
            endcase
          end
        end
        DESEL: begin
          if (r_cnt == 8'd1) begin
            r_cnt <= '0;
            if (r_push) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= DONE;
            end else begin
              wstrobe_d <= 1'b1;
              dread     <= r_buf[0];
              r_state   <= FILL;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // The last fill nibble is presented in DONE, so done coincides with it.
        FILL: begin
          dread <= r_buf[w_idx_nx];
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == c_fill_last) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          wstrobe_d <= 1'b0;
          dread     <= 4'h0;
          r_cnt     <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_qspi.sv
`default_nettype none
// ==== tb_dcache_qspi : scoreboard bench for dcache_qspi with PSRAM and cache models (rev 1.0) ====
module tb_dcache_qspi;

  localparam int NN = 8;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0, push = 1'b0, pull = 1'b0;
  logic [TW-1:0] tag = '0;
  logic [3:0]    dwrite, dread, qspi_out;
  logic [3:0]    qspi_in = 4'h0;
  logic          wstrobe_d, rstrobe_d, busy, done, qspi_sck, qspi_cs_n, qspi_oe;

  dcache_qspi dut (
    .clk(clk), .reset_n(reset_n), .req(req), .push(push), .pull(pull), .tag(tag),
    .dwrite(dwrite), .dread(dread), .wstrobe_d(wstrobe_d), .rstrobe_d(rstrobe_d),
    .busy(busy), .done(done), .qspi_sck(qspi_sck), .qspi_cs_n(qspi_cs_n),
    .qspi_oe(qspi_oe), .qspi_out(qspi_out), .qspi_in(qspi_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int t_acc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // PSRAM: read data nibbles follow 2 cmd + 6 addr + 6 dummy slots and count 1..8.
  int nib_idx = 0;
  always @(posedge qspi_sck or posedge qspi_cs_n) begin
    if (qspi_cs_n) nib_idx = 0;
    else begin
      qspi_in = (nib_idx >= 14 && nib_idx < 22) ? 4'(nib_idx - 13) : 4'h0;
      nib_idx++;
    end
  end

  // Cache side: offset counter that restarts on any strobe gap.
  logic [3:0] wb_line   [NN];
  logic [3:0] fill_line [NN];
  logic       valid = 1'b0;
  logic       inval = 1'b0;
  logic [2:0] off   = 3'd0;
  assign dwrite = wb_line[off];
  always @(posedge clk) begin
    if (wstrobe_d) begin
      fill_line[off] <= dread;
      if (off == 3'd7) valid <= 1'b1;
    end else if (inval) valid <= 1'b0;
    off <= (wstrobe_d || rstrobe_d) ? off + 3'd1 : 3'd0;
  end

  // Scoreboard queues
  typedef struct { int rel; int val; } fill_t;
  int    bus_q[$];
  int    rs_q[$];
  int    done_q[$];
  fill_t fill_q[$];

  task automatic expect_txn(input logic [TW-1:0] t, input bit is_push);
    logic [31:0] ca;
    ca = {(is_push ? 8'h38 : 8'hEB), 2'b00, t, 2'b00};
    for (int i = 0; i < 8; i++) bus_q.push_back(int'(ca[31-4*i -: 4]));
    if (is_push) begin
      for (int i = 0; i < NN; i++) begin
        bus_q.push_back(int'(wb_line[i]));
        rs_q.push_back(i + 1);
      end
      done_q.push_back(43);
    end else begin
      for (int i = 0; i < 6 + NN; i++) bus_q.push_back(-1);
      for (int i = 0; i < NN; i++) fill_q.push_back('{47 + i, i + 1});
      done_q.push_back(54);
    end
  endtask

  // Monitor
  int    rel_m, e_m, cs_hi_run = 0;
  bit    seen_window = 1'b0;
  logic  prev_cs = 1'b1;
  fill_t f_m;
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      rel_m = cyc - t_acc + 1;
      if (!qspi_cs_n && qspi_sck) begin
        if (bus_q.size() == 0) chk("bus_unexpected_slot", 1, 0);
        else begin
          e_m = bus_q.pop_front();
          if (e_m < 0) chk("bus_oe_low", int'(qspi_oe), 0);
          else chk("bus_nibble", int'({qspi_oe, qspi_out}), 16 + e_m);
        end
      end
      if (rstrobe_d) begin
        if (rs_q.size() == 0) chk("rstrobe_unexpected", 1, 0);
        else chk("rstrobe_cycle", rel_m, rs_q.pop_front());
      end
      if (wstrobe_d) begin
        if (fill_q.size() == 0) chk("wstrobe_unexpected", 1, 0);
        else begin
          f_m = fill_q.pop_front();
          chk("fill_cycle", rel_m, f_m.rel);
          chk("fill_data", int'(dread), f_m.val);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", rel_m, done_q.pop_front());
      end
      if (qspi_cs_n) cs_hi_run++;
      else begin
        if (prev_cs && seen_window) chk("cs_gap_min2", int'(cs_hi_run >= 2), 1);
        seen_window = 1'b1;
        cs_hi_run   = 0;
      end
      prev_cs = qspi_cs_n;
    end
  end

  function automatic int outs();
    return int'({qspi_cs_n, qspi_sck, qspi_oe, qspi_out, dread, wstrobe_d, rstrobe_d, busy, done});
  endfunction

  task automatic wait_done(input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (cyc - t_acc + 1 == 5) chk("busy_mid_txn", int'(busy), 1);
      if (toggle && cyc - t_acc + 1 == 10) push = 1'b1;
      if (toggle && cyc - t_acc + 1 == 20) push = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", int'(seen), 1);
  endtask

  function automatic int fill_word();
    logic [31:0] v;
    for (int i = 0; i < NN; i++) v[31-4*i -: 4] = fill_line[i];
    return int'(v);
  endfunction

  bit hit;

  initial begin
    for (int i = 0; i < NN; i++) wb_line[i] = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), int'(15'h4000));
    reset_n = 1'b1;

    // Hit: no transfer requested
    @(negedge clk);
    tag = 20'h00055; req = 1'b1;
    repeat (6) @(negedge clk);
    chk("hit_cs_n", int'(qspi_cs_n), 1);
    chk("hit_busy", int'(busy), 0);
    req = 1'b0;
    @(negedge clk);

    // Pull cut by reset in fill burst cycle 4
    tag = 20'h12345;
    expect_txn(tag, 1'b0);
    req = 1'b1; pull = 1'b1; t_acc = cyc + 1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (cyc - t_acc + 1 == 51) hit = 1'b1;
    end
    chk("reach_fill_cycle4", int'(hit), 1);
    chk("wstrobe_at_cut", int'(wstrobe_d), 1);
    #1 reset_n = 1'b0; req = 1'b0; pull = 1'b0;
    #1 chk("reset_mid_fill", outs(), int'(15'h4000));
    chk("bus_q_drained", bus_q.size(), 0);
    fill_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    chk("valid_after_abort", int'(valid), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fresh pull, push toggled mid-transaction
    expect_txn(tag, 1'b0);
    req = 1'b1; pull = 1'b1; t_acc = cyc + 1;
    wait_done(1'b1);
    req = 1'b0; pull = 1'b0;
    repeat (2) @(negedge clk);
    chk("pull_valid", int'(valid), 1);
    chk("pull_line", fill_word(), 32'h12345678);
    chk("idle_busy", int'(busy), 0);

    // Push write-back
    wb_line = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    tag = 20'h00001;
    expect_txn(tag, 1'b1);
    req = 1'b1; push = 1'b1; t_acc = cyc + 1;
    wait_done(1'b0);
    req = 1'b0; push = 1'b0;
    repeat (2) @(negedge clk);

    // Push then re-requested pull on the same line
    inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
    @(negedge clk);
    chk("invalidated", int'(valid), 0);
    wb_line = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    tag = 20'h00002;
    expect_txn(tag, 1'b1);
    req = 1'b1; push = 1'b1; t_acc = cyc + 1;
    wait_done(1'b0);
    push = 1'b0; pull = 1'b1; t_acc = cyc + 2;
    expect_txn(tag, 1'b0);
    wait_done(1'b0);
    req = 1'b0; pull = 1'b0;
    repeat (3) @(negedge clk);
    chk("refill_hit", int'(valid), 1);
    chk("refill_line", fill_word(), 32'h12345678);
    chk("queues_empty", bus_q.size() + rs_q.size() + fill_q.size() + done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
